// File: rtl/pac_pkg.sv
// pac_pkg: shared types, address map and unlock defaults for the PAC memory sequencer.
//   state_t       : sequencer FSM states
//   *_ADDR, WIN_* : unlock register addresses and the 4000h-7FFFh slot window
//   DEF_UNLOCK_*  : default unlock byte pair that enables RAM mode
package pac_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, PRECHARGE} state_t;

    localparam logic [15:0] REG_LO_ADDR = 16'h5FFE;
    localparam logic [15:0] REG_HI_ADDR = 16'h5FFF;
    localparam logic [15:0] WIN_BASE    = 16'h4000;
    localparam logic [15:0] WIN_TOP     = 16'h7FFF;

    localparam logic [7:0] DEF_UNLOCK_LO = 8'h4D;
    localparam logic [7:0] DEF_UNLOCK_HI = 8'h69;

    function automatic logic in_window(input logic [15:0] addr);
        return addr >= WIN_BASE && addr <= WIN_TOP;
    endfunction

    function automatic logic is_reg_addr(input logic [15:0] addr);
        return addr == REG_LO_ADDR || addr == REG_HI_ADDR;
    endfunction

endpackage

// File: rtl/pac_unlock_regs.sv
// pac_unlock_regs: unlock register pair, unlock compare, registered ram_mode and readback.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : one-clock write pulse, loads the register chosen by sel_hi from wdata
//   rd_en      : one-clock read pulse, latches the chosen register into rdata
//   sel_hi     : 0 = low register (5FFEh), 1 = high register (5FFFh)
//   rdata      : registered readback
//   ram_mode   : registered unlock match, lags a register write by one clock
module pac_unlock_regs
    import pac_pkg::*;
#(
    parameter logic [7:0] UNLOCK_LO = DEF_UNLOCK_LO,
    parameter logic [7:0] UNLOCK_HI = DEF_UNLOCK_HI
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic       sel_hi,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       ram_mode
);

    logic [7:0] reg_lo;
    logic [7:0] reg_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_lo   <= 8'h00;
            reg_hi   <= 8'h00;
            rdata    <= 8'h00;
            ram_mode <= 1'b0;
        end else begin
            if (wr_en && !sel_hi) reg_lo <= wdata;
            if (wr_en && sel_hi) reg_hi <= wdata;
            if (rd_en) rdata <= sel_hi ? reg_hi : reg_lo;
            ram_mode <= (reg_lo == UNLOCK_LO) && (reg_hi == UNLOCK_HI);
        end
    end

endmodule

// File: rtl/pac_mem_sequencer.sv
// pac_mem_sequencer: slot bus-cycle sequencer driving flash ROM / FRAM strobes with FRAM precharge.
//   SLT_CLOCK, SLT_RESETn          : slot clock, asynchronous active-low reset
//   SLT_SLTSL, SLT_RDn, SLT_WEn    : slot select and strobes (active low)
//   SLT_A, SLT_DI                  : slot address and write data
//   ROM_CEn, FRAM_CEn              : registered chip enables (active low)
//   ROM_OEn, ROM_WEn               : registered shared output / write enables (active low)
//   SLT_WAITn                      : registered slot wait request (active low)
//   SLT_D_OE, reg_rdata            : unlock register readback drive enable and data
//   ram_mode                       : 4000h-5FFDh mapped to FRAM
module pac_mem_sequencer
    import pac_pkg::*;
#(
    parameter logic [7:0] UNLOCK_LO     = DEF_UNLOCK_LO,
    parameter logic [7:0] UNLOCK_HI     = DEF_UNLOCK_HI,
    parameter int         PRECHARGE_CYC = 1
) (
    input  logic        SLT_CLOCK,
    input  logic        SLT_RESETn,
    input  logic        SLT_SLTSL,
    input  logic        SLT_RDn,
    input  logic        SLT_WEn,
    input  logic [15:0] SLT_A,
    input  logic [7:0]  SLT_DI,
    output logic        ROM_CEn,
    output logic        FRAM_CEn,
    output logic        ROM_OEn,
    output logic        ROM_WEn,
    output logic        SLT_WAITn,
    output logic        SLT_D_OE,
    output logic [7:0]  reg_rdata,
    output logic        ram_mode
);

    // Counter is loaded with one less than the precharge length so that the
    // exit edge is the one that sees zero.
    localparam logic [2:0] PC_LOAD = 3'(PRECHARGE_CYC - 1);

    state_t     state;
    logic [2:0] cnt;
    logic       is_wr;
    logic       rd_req;
    logic       wr_req;
    logic       req;
    logic       entry;
    logic       hold;
    logic       is_reg;
    logic       is_ram;

    always_comb begin
        rd_req = !SLT_SLTSL && in_window(SLT_A) && !SLT_RDn && SLT_WEn;
        wr_req = !SLT_SLTSL && in_window(SLT_A) && SLT_RDn && !SLT_WEn;
        req    = rd_req || wr_req;
        // A request waiting out precharge is taken on the exit edge itself.
        entry  = req && (state == IDLE || (state == PRECHARGE && cnt == 3'd0));
        hold   = !SLT_SLTSL && (is_wr ? !SLT_WEn : !SLT_RDn);
        is_reg = is_reg_addr(SLT_A);
        is_ram = ram_mode && SLT_A >= WIN_BASE && SLT_A < REG_LO_ADDR;
    end

    always_ff @(posedge SLT_CLOCK or negedge SLT_RESETn) begin
        if (!SLT_RESETn) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            is_wr     <= 1'b0;
            ROM_CEn   <= 1'b1;
            FRAM_CEn  <= 1'b1;
            ROM_OEn   <= 1'b1;
            ROM_WEn   <= 1'b1;
            SLT_WAITn <= 1'b1;
            SLT_D_OE  <= 1'b0;
        end else if (entry) begin
            state     <= ACTIVE;
            is_wr     <= wr_req;
            SLT_WAITn <= 1'b1;
            // Writes outside FRAM are dropped: no flash write path exists.
            ROM_CEn   <= !(rd_req && !is_reg && !is_ram);
            FRAM_CEn  <= !is_ram;
            ROM_OEn   <= !(rd_req && !is_reg);
            ROM_WEn   <= !(wr_req && is_ram);
            SLT_D_OE  <= rd_req && is_reg;
        end else if (state == ACTIVE && !hold) begin
            state     <= PRECHARGE;
            cnt       <= PC_LOAD;
            ROM_CEn   <= 1'b1;
            FRAM_CEn  <= 1'b1;
            ROM_OEn   <= 1'b1;
            ROM_WEn   <= 1'b1;
            SLT_D_OE  <= 1'b0;
        end else if (state == PRECHARGE) begin
            state     <= (cnt == 3'd0) ? IDLE : PRECHARGE;
            cnt       <= (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
            SLT_WAITn <= !req;
        end
    end

    pac_unlock_regs #(
        .UNLOCK_LO (UNLOCK_LO),
        .UNLOCK_HI (UNLOCK_HI)
    ) u_regs (
        .clk      (SLT_CLOCK),
        .rst_n    (SLT_RESETn),
        .wr_en    (entry && wr_req && is_reg),
        .rd_en    (entry && rd_req && is_reg),
        .sel_hi   (SLT_A[0]),
        .wdata    (SLT_DI),
        .rdata    (reg_rdata),
        .ram_mode (ram_mode)
    );

endmodule

// File: tb/tb_pac_mem_sequencer.sv
// tb_pac_mem_sequencer: directed and randomized bus cycles checked against a behavioural slot model.
module tb_pac_mem_sequencer;

    localparam int PC = 3;

    logic        SLT_CLOCK = 1'b0;
    logic        SLT_RESETn;
    logic        SLT_SLTSL;
    logic        SLT_RDn;
    logic        SLT_WEn;
    logic [15:0] SLT_A;
    logic [7:0]  SLT_DI;
    logic        ROM_CEn;
    logic        FRAM_CEn;
    logic        ROM_OEn;
    logic        ROM_WEn;
    logic        SLT_WAITn;
    logic        SLT_D_OE;
    logic [7:0]  reg_rdata;
    logic        ram_mode;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_rel = -100;

    logic [7:0] m_lo = 8'h00;
    logic [7:0] m_hi = 8'h00;
    logic [7:0] m_rdata = 8'h00;

    pac_mem_sequencer #(.PRECHARGE_CYC(PC)) dut (
        .SLT_CLOCK  (SLT_CLOCK),
        .SLT_RESETn (SLT_RESETn),
        .SLT_SLTSL  (SLT_SLTSL),
        .SLT_RDn    (SLT_RDn),
        .SLT_WEn    (SLT_WEn),
        .SLT_A      (SLT_A),
        .SLT_DI     (SLT_DI),
        .ROM_CEn    (ROM_CEn),
        .FRAM_CEn   (FRAM_CEn),
        .ROM_OEn    (ROM_OEn),
        .ROM_WEn    (ROM_WEn),
        .SLT_WAITn  (SLT_WAITn),
        .SLT_D_OE   (SLT_D_OE),
        .reg_rdata  (reg_rdata),
        .ram_mode   (ram_mode)
    );

    always #5 SLT_CLOCK = ~SLT_CLOCK;
    always @(posedge SLT_CLOCK) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // {ROM_CEn, FRAM_CEn, ROM_OEn, ROM_WEn, SLT_WAITn, SLT_D_OE}
    function automatic logic [5:0] pins();
        return {ROM_CEn, FRAM_CEn, ROM_OEn, ROM_WEn, SLT_WAITn, SLT_D_OE};
    endfunction

    function automatic logic m_ram();
        return m_lo == 8'h4D && m_hi == 8'h69;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        SLT_SLTSL = 1'b1;
        SLT_RDn   = 1'b1;
        SLT_WEn   = 1'b1;
    endtask

    // One slot cycle: the model decides whether it must wait out the
    // precharge window opened by the previous release, and what it enables.
    task automatic access(input logic [15:0] addr, input bit wr, input logic [7:0] data,
                          input int hold, input int gap);
        int s;
        int e;
        bit regacc;
        logic [5:0] exp;
        repeat (gap) @(negedge SLT_CLOCK);
        SLT_A = addr; SLT_DI = data; SLT_SLTSL = 1'b0; SLT_RDn = wr; SLT_WEn = !wr;
        s = cyc + 1;
        e = (s > last_rel + PC) ? s : last_rel + PC;
        regacc = addr == 16'h5FFE || addr == 16'h5FFF;
        exp = 6'b111110;
        if (regacc && !wr) begin
            exp[0] = 1'b1;
            m_rdata = addr[0] ? m_hi : m_lo;
        end else if (!regacc && m_ram() && addr < 16'h5FFE) begin
            exp[4] = 1'b0;
            if (wr) exp[2] = 1'b0; else exp[3] = 1'b0;
        end else if (!regacc && !wr) begin
            exp[5] = 1'b0;
            exp[3] = 1'b0;
        end
        for (int k = s; k < e; k++) begin
            @(negedge SLT_CLOCK);
            check("wait", 8'(pins()), 8'(6'b111100));
        end
        @(negedge SLT_CLOCK);
        check("strobe", 8'(pins()), 8'(exp));
        check("rdata", reg_rdata, m_rdata);
        if (regacc && wr) begin
            if (addr[0]) m_hi = data; else m_lo = data;
        end
        for (int k = 1; k < hold; k++) begin
            @(negedge SLT_CLOCK);
            check("hold", 8'(pins()), 8'(exp));
        end
        idle_bus();
        @(negedge SLT_CLOCK);
        last_rel = cyc;
        check("release", 8'(pins()), 8'(6'b111110));
        check("ram_mode", 8'(ram_mode), 8'(m_ram()));
    endtask

    initial begin
        SLT_RESETn = 1'b0;
        SLT_A = 16'h0000;
        SLT_DI = 8'h00;
        idle_bus();
        repeat (2) @(negedge SLT_CLOCK);
        check("rst_pins", 8'(pins()), 8'(6'b111110));
        check("rst_rdata", reg_rdata, 8'h00);
        check("rst_ram_mode", 8'(ram_mode), 8'h00);
        SLT_RESETn = 1'b1;
        repeat (2) @(negedge SLT_CLOCK);

        access(16'h4000, 1'b0, 8'h00, 2, 0);
        access(16'h5FFE, 1'b1, 8'h4D, 2, 4);
        access(16'h5FFF, 1'b1, 8'h69, 1, 4);
        access(16'h4000, 1'b0, 8'h00, 1, 4);
        access(16'h6000, 1'b0, 8'h00, 1, 4);
        access(16'h4001, 1'b1, 8'h11, 3, 4);
        access(16'h4002, 1'b0, 8'h00, 1, 0);
        access(16'h5FFF, 1'b1, 8'h00, 1, 4);
        access(16'h4000, 1'b1, 8'h22, 2, 4);
        access(16'h5FFF, 1'b0, 8'h00, 1, 4);
        access(16'h4000, 1'b0, 8'h00, 1, 4);
        access(16'h4000, 1'b0, 8'h00, 1, 0);

        // Both strobes low is not a cycle.
        repeat (4) @(negedge SLT_CLOCK);
        SLT_A = 16'h4000; SLT_SLTSL = 1'b0; SLT_RDn = 1'b0; SLT_WEn = 1'b0;
        repeat (3) begin
            @(negedge SLT_CLOCK);
            check("illegal", 8'(pins()), 8'(6'b111110));
        end
        idle_bus();

        for (int i = 0; i < 40; i++) begin
            logic [15:0] addr;
            logic [7:0]  data;
            int          sel;
            bit          wr;
            sel  = int'($urandom_range(3, 0));
            wr   = 1'($urandom);
            data = 8'($urandom);
            addr = sel == 0 ? 16'h5FFE : sel == 1 ? 16'h5FFF
                 : sel == 2 ? 16'($urandom_range(16'h5FFD, 16'h4000))
                 : 16'($urandom_range(16'h7FFF, 16'h4000));
            if (sel < 2 && $urandom_range(1, 0) == 1) data = sel == 0 ? 8'h4D : 8'h69;
            access(addr, wr, data, int'($urandom_range(3, 1)), int'($urandom_range(4, 0)));
        end

        // Unlock, then pull reset in the middle of an FRAM write.
        access(16'h5FFE, 1'b1, 8'h4D, 1, 4);
        access(16'h5FFF, 1'b1, 8'h69, 1, 4);
        repeat (4) @(negedge SLT_CLOCK);
        SLT_A = 16'h4001; SLT_DI = 8'h5A; SLT_SLTSL = 1'b0; SLT_RDn = 1'b1; SLT_WEn = 1'b0;
        @(negedge SLT_CLOCK);
        check("fram_wr", 8'(pins()), 8'(6'b101010));
        #2 SLT_RESETn = 1'b0;
        #1;
        check("async_rst_pins", 8'(pins()), 8'(6'b111110));
        check("async_rst_ram_mode", 8'(ram_mode), 8'h00);
        check("async_rst_rdata", reg_rdata, 8'h00);
        idle_bus();
        @(negedge SLT_CLOCK);
        SLT_RESETn = 1'b1;
        m_lo = 8'h00; m_hi = 8'h00; m_rdata = 8'h00; last_rel = -100;
        access(16'h4000, 1'b0, 8'h00, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
